// File: rtl/ddr3_arb_pkg.sv
// Shared constants and types for the DDR3 native-port arbiter.
package ddr3_arb_pkg;

  localparam logic [2:0]  CMD_WR  = 3'b000;
  localparam logic [2:0]  CMD_RD  = 3'b001;
  localparam logic [7:0]  WR_MASK = 8'hC0;
  localparam int unsigned PIX_W   = 48;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD
  } arb_state_e;

endpackage

// File: rtl/ddr3_app_arbiter_if.sv
// Native command/data port of the DDR3 memory-interface IP.
// master = arbiter side, slave = IP side.
interface ddr3_app_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 28
);

  logic                  cmd_ready;
  logic                  cmd_en;
  logic [2:0]            cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_data_rdy;
  logic                  wr_data_en;
  logic                  wr_data_end;
  logic [63:0]           app_wdf_data;
  logic [7:0]            wr_data_mask;
  logic [63:0]           app_rd_data;
  logic                  rd_data_valid;

  modport master (
    input  cmd_ready, wr_data_rdy, app_rd_data, rd_data_valid,
    output cmd_en, cmd, addr, wr_data_en, wr_data_end, app_wdf_data, wr_data_mask
  );

  modport slave (
    output cmd_ready, wr_data_rdy, app_rd_data, rd_data_valid,
    input  cmd_en, cmd, addr, wr_data_en, wr_data_end, app_wdf_data, wr_data_mask
  );

endinterface

// File: rtl/ddr3_rd_tracker.sv
// Outstanding-read counter, spurious-return error flag and the read-data
// return register stage.
module ddr3_rd_tracker
  import ddr3_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_grant,
  input  logic             i_ret,
  input  logic [PIX_W-1:0] i_rdata,
  output logic             o_rd_valid,
  output logic [PIX_W-1:0] o_rd_data,
  output logic [3:0]       o_cnt,
  output logic             o_err
);

  logic             r_valid;
  logic [PIX_W-1:0] r_data;
  logic [3:0]       r_cnt;
  logic             r_err;

  // One-cycle register stage on returned read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_ret;
      r_data  <= i_rdata;
    end
  end

  // Outstanding count: +1 per read grant, -1 per return; a return with
  // nothing outstanding leaves the count at 0 and sets the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_ret && (r_cnt == 4'd0)) r_err <= 1'b1;
      unique case ({i_grant, i_ret})
        2'b10:   r_cnt <= r_cnt + 4'd1;
        2'b01:   if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_rd_valid = r_valid;
  assign o_rd_data  = r_data;
  assign o_cnt      = r_cnt;
  assign o_err      = r_err;

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Round-robin arbiter sharing the DDR3 IP native port between one pixel
// writer and one pixel reader; bounds outstanding reads.
module ddr3_app_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] WR_BASE    = '0,
  parameter logic [ADDR_WIDTH-1:0] RD_BASE    = '0,
  parameter int unsigned           MAX_RD_OUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_calib_complete,
  input  logic                wr_req,
  input  logic [15:0]         wr_addr,
  input  logic [PIX_W-1:0]    wr_data,
  output logic                wr_ack,
  input  logic                rd_req,
  input  logic [15:0]         rd_addr,
  output logic                rd_ack,
  output logic                rd_valid,
  output logic [PIX_W-1:0]    rd_data,
  ddr3_app_arbiter_if.master  ip,
  output logic [3:0]          rd_out_cnt,
  output logic                err_flag
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_RD_OUT);

  arb_state_e            r_state;
  logic                  r_last_wr;
  logic                  r_wr_ack;
  logic                  r_rd_ack;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [63:0]           r_wdata;
  logic [2:0]            r_cmd;
  logic                  r_cmd_en;
  logic                  r_wd_en;
  logic [7:0]            r_mask;

  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_cmd_hs;
  logic                  w_wd_hs;
  logic                  w_cmd_pend;
  logic                  w_wd_pend;
  logic [ADDR_WIDTH-1:0] w_wr_ip_addr;
  logic [ADDR_WIDTH-1:0] w_rd_ip_addr;
  logic [3:0]            w_cnt;
  logic                  w_unused_hi;

  assign w_wr_elig  = init_calib_complete & wr_req;
  assign w_rd_elig  = init_calib_complete & rd_req & (w_cnt < MAX_OUT);
  assign w_grant_wr = (r_state == ST_IDLE) & w_wr_elig & (~w_rd_elig | ~r_last_wr);
  assign w_grant_rd = (r_state == ST_IDLE) & w_rd_elig & (~w_wr_elig |  r_last_wr);

  assign w_cmd_hs   = r_cmd_en &  ip.cmd_ready;
  assign w_cmd_pend = r_cmd_en & ~ip.cmd_ready;
  assign w_wd_hs    = r_wd_en  &  ip.wr_data_rdy;
  assign w_wd_pend  = r_wd_en  & ~ip.wr_data_rdy;

  assign w_wr_ip_addr = WR_BASE + ADDR_WIDTH'({wr_addr, 2'b00});
  assign w_rd_ip_addr = RD_BASE + ADDR_WIDTH'({rd_addr, 2'b00});

  // Arbitration FSM; every IP-side output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last_wr <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cmd     <= '0;
      r_cmd_en  <= 1'b0;
      r_wd_en   <= 1'b0;
      r_mask    <= '1;
    end else begin
      r_wr_ack <= 1'b0;
      r_rd_ack <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_wr) begin
            r_addr    <= w_wr_ip_addr;
            r_wdata   <= {16'h0000, wr_data};
            r_cmd     <= CMD_WR;
            r_cmd_en  <= 1'b1;
            r_wd_en   <= 1'b1;
            r_mask    <= WR_MASK;
            r_last_wr <= 1'b1;
            r_wr_ack  <= 1'b1;
            r_state   <= ST_WR;
          end else if (w_grant_rd) begin
            r_addr    <= w_rd_ip_addr;
            r_cmd     <= CMD_RD;
            r_cmd_en  <= 1'b1;
            r_last_wr <= 1'b0;
            r_rd_ack  <= 1'b1;
            r_state   <= ST_RD;
          end
        end
        ST_WR: begin
          // Command and data handshakes retire independently.
          if (w_cmd_hs) r_cmd_en <= 1'b0;
          if (w_wd_hs) begin
            r_wd_en <= 1'b0;
            r_mask  <= '1;
          end
          if (!w_cmd_pend && !w_wd_pend) r_state <= ST_IDLE;
        end
        ST_RD: begin
          if (w_cmd_hs) begin
            r_cmd_en <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ddr3_rd_tracker u_rd_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_grant    (w_grant_rd),
    .i_ret      (ip.rd_data_valid),
    .i_rdata    (ip.app_rd_data[PIX_W-1:0]),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .o_cnt      (w_cnt),
    .o_err      (err_flag)
  );

  assign w_unused_hi = ^ip.app_rd_data[63:PIX_W];

  assign wr_ack          = r_wr_ack;
  assign rd_ack          = r_rd_ack;
  assign rd_out_cnt      = w_cnt;
  assign ip.cmd_en       = r_cmd_en;
  assign ip.cmd          = r_cmd;
  assign ip.addr         = r_addr;
  assign ip.wr_data_en   = r_wd_en;
  assign ip.wr_data_end  = r_wd_en;
  assign ip.app_wdf_data = r_wdata;
  assign ip.wr_data_mask = r_mask;

endmodule
